// File: rtl/menu_bg_gen.sv
// Raster timing generator with a registered background pattern (noise-wave, solid,
// colour bars, grey gradient) for the MENU pixel domain, ahead of the OSD overlay.
module menu_bg_gen #(
   parameter int H_TOTAL      = 640,
   parameter int H_BL_START   = 310,
   parameter int H_BL_END     = 420,
   parameter int H_SYNC_START = 336,
   parameter int H_SYNC_END   = 368,
   parameter int V_TOTAL      = 312,
   parameter int V_BL_START   = 306,
   parameter int V_BL_END     = 2,
   parameter int V_SYNC_START = 308,
   parameter int V_SYNC_END   = 0,
   parameter int DW           = 6,
   parameter int NOISE_BITS   = 3,
   parameter int SCROLL_STEP  = 6,
   parameter int BAR_SHIFT    = 4,
   parameter int GRAD_SHIFT   = 1
) (
   input  logic            clk_pix,
   input  logic            reset_n,
   input  logic [1:0]      mode,
   input  logic [3*DW-1:0] color,
   input  logic            freeze,
   output logic [DW-1:0]   r,
   output logic [DW-1:0]   g,
   output logic [DW-1:0]   b,
   output logic            hs,
   output logic            vs,
   output logic            hblank,
   output logic            vblank,
   output logic            de,
   output logic            frame_start
);

   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] HBS    = HW'(H_BL_START);
   localparam logic [HW-1:0] HBE    = HW'(H_BL_END);
   localparam logic [HW-1:0] HSS    = HW'(H_SYNC_START);
   localparam logic [HW-1:0] HSE    = HW'(H_SYNC_END);
   localparam logic [HW-1:0] X_WRAP = HW'(H_TOTAL - H_BL_END);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] VBS    = VW'(V_BL_START);
   localparam logic [VW-1:0] VBE    = VW'(V_BL_END);
   localparam logic [VW-1:0] VSS    = VW'(V_SYNC_START);
   localparam logic [VW-1:0] VSE    = VW'(V_SYNC_END);
   localparam logic [DW-1:0] MID    = DW'(1) << (DW - 1);

   typedef enum logic [1:0] {
      PAT_WAVE  = 2'd0,
      PAT_SOLID = 2'd1,
      PAT_BARS  = 2'd2,
      PAT_GRAD  = 2'd3
   } pat_e;

   logic [HW-1:0]   hc;
   logic [VW-1:0]   vc;
   logic [7:0]      phase;
   logic [22:0]     lfsr;
   pat_e            mode_q;
   logic [3*DW-1:0] color_q;

   logic [HW-1:0]   hc_next;
   logic [VW-1:0]   vc_next;
   logic            h_last;
   logic            frame_wrap;
   logic            hblank_next;
   logic            vblank_next;
   logic            hs_next;
   logic            vs_next;
   logic            de_next;
   logic [HW-1:0]   x;
   logic [7:0]      vc8;
   logic [7:0]      idx;
   logic [6:0]      wave;
   logic [DW-1:0]   base;
   logic [DW-1:0]   noise;
   logic [DW-1:0]   wave_pix;
   logic [2:0]      bar_k;
   logic [DW-1:0]   grad_pix;
   logic [DW-1:0]   pix_r;
   logic [DW-1:0]   pix_g;
   logic [DW-1:0]   pix_b;

   // Set takes priority so a misconfigured set==clear pair leaves the flag asserted.
   function automatic logic edge_flag(input logic cur, input logic set, input logic clr);
      return set ? 1'b1 : (clr ? 1'b0 : cur);
   endfunction

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      vc_next    = vc;
      h_last     = (hc == H_LAST);
      frame_wrap = h_last && (vc == V_LAST);
      hc_next    = h_last ? '0 : hc + HW'(1);
      if (h_last)
         vc_next = (vc == V_LAST) ? '0 : vc + VW'(1);

      // Horizontal flags act on the column; vertical flags act on the last column of a line.
      hblank_next = edge_flag(hblank, hc == HBS, hc == HBE);
      hs_next     = edge_flag(hs, hc == HSS, hc == HSE);
      vblank_next = h_last ? edge_flag(vblank, vc == VBS, vc == VBE) : vblank;
      vs_next     = h_last ? edge_flag(vs, vc == VSS, vc == VSE) : vs;
      de_next     = !hblank_next && !vblank_next;
   end

   always_comb begin
      x        = (hc >= HBE) ? hc - HBE : hc + X_WRAP;
      vc8      = 8'(vc);
      idx      = phase + {vc8[5:0], 2'b00};
      wave     = idx[7] ? ~idx[6:0] : idx[6:0];
      base     = MID + DW'(wave >> (8 - DW));
      noise    = DW'(lfsr[NOISE_BITS-1:0]);
      wave_pix = (base >= noise) ? base - noise : '0;
      bar_k    = 3'(x >> BAR_SHIFT);
      grad_pix = DW'(x >> GRAD_SHIFT);
   end

   always_comb begin
      pix_r = '0;
      pix_g = '0;
      pix_b = '0;
      case (mode_q)
         PAT_WAVE: begin
            pix_r = wave_pix;
            pix_g = wave_pix;
            pix_b = wave_pix;
         end
         PAT_SOLID: {pix_r, pix_g, pix_b} = color_q;
         PAT_BARS: begin
            pix_r = {DW{~bar_k[2]}};
            pix_g = {DW{~bar_k[1]}};
            pix_b = {DW{~bar_k[0]}};
         end
         PAT_GRAD: begin
            pix_r = grad_pix;
            pix_g = grad_pix;
            pix_b = grad_pix;
         end
         default: ;
      endcase
      if (!de_next) begin
         pix_r = '0;
         pix_g = '0;
         pix_b = '0;
      end
   end

   // Raster position, scroll phase, noise source and per-frame pattern selection.
   always_ff @(posedge clk_pix or negedge reset_n) begin
      if (!reset_n) begin
         hc      <= '0;
         vc      <= '0;
         phase   <= '0;
         lfsr    <= 23'h7FFFFF;
         mode_q  <= PAT_WAVE;
         color_q <= '0;
      end else begin
         // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
         hc   <= hc_next;
         vc   <= vc_next;
         lfsr <= {lfsr[21:0], lfsr[22] ^ lfsr[17]};
         if (frame_wrap) begin
            mode_q  <= pat_e'(mode);
            color_q <= color;
            if (!freeze)
               phase <= phase + 8'(SCROLL_STEP);
         end
      end
   end

   always_ff @(posedge clk_pix or negedge reset_n) begin
      if (!reset_n) begin
         hblank      <= 1'b1;
         vblank      <= 1'b1;
         hs          <= 1'b0;
         vs          <= 1'b0;
         de          <= 1'b0;
         frame_start <= 1'b0;
         r           <= '0;
         g           <= '0;
         b           <= '0;
      end else begin
         hblank      <= hblank_next;
         vblank      <= vblank_next;
         hs          <= hs_next;
         vs          <= vs_next;
         de          <= de_next;
         frame_start <= frame_wrap;
         r           <= pix_r;
         g           <= pix_g;
         b           <= pix_b;
      end
   end

endmodule

// File: tb/tb_menu_bg_gen.sv
// Randomised self-checking bench for menu_bg_gen on a reduced raster, compared cycle by
// cycle against a position-based behavioural model of the pattern and timing rules.
module tb_menu_bg_gen;

   localparam int DW    = 6;
   localparam int NB    = 3;
   localparam int HT    = 48;
   localparam int HBS   = 40;
   localparam int HBE   = 6;
   localparam int HSS   = 44;
   localparam int HSE   = 2;
   localparam int VT    = 20;
   localparam int VBS   = 17;
   localparam int VBE   = 2;
   localparam int VSS   = 18;
   localparam int VSE   = 0;
   localparam int STEP  = 6;
   localparam int BS    = 2;
   localparam int GS    = 1;
   localparam int FRAME = HT * VT;
   localparam int MAXV  = 2**DW - 1;
   localparam int LO    = 2**(DW-1) - (2**NB - 1);
   localparam int OW    = 3*DW + 6;
   localparam logic [OW-1:0] RST_VEC = OW'(6'b001100);

   logic            clk_pix = 1'b0;
   logic            reset_n = 1'b1;
   logic [1:0]      mode    = 2'd0;
   logic [3*DW-1:0] color   = '0;
   logic            freeze  = 1'b0;
   logic [DW-1:0]   r, g, b;
   logic            hs, vs, hblank, vblank, de, frame_start;

   int checks = 0;
   int errors = 0;

   int              m_t, m_phase, m_mode, m_edges, m_last_fs;
   int              m_fs_cnt   = 0;
   int              dut_fs_cnt = 0;
   bit              m_hb, m_vb, m_hs, m_vs;
   logic [22:0]     m_lfsr;
   logic [3*DW-1:0] m_color;

   menu_bg_gen #(
      .H_TOTAL(HT), .H_BL_START(HBS), .H_BL_END(HBE), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
      .V_TOTAL(VT), .V_BL_START(VBS), .V_BL_END(VBE), .V_SYNC_START(VSS), .V_SYNC_END(VSE),
      .DW(DW), .NOISE_BITS(NB), .SCROLL_STEP(STEP), .BAR_SHIFT(BS), .GRAD_SHIFT(GS)
   ) dut (
      .clk_pix(clk_pix), .reset_n(reset_n), .mode(mode), .color(color), .freeze(freeze),
      .r(r), .g(g), .b(b), .hs(hs), .vs(vs), .hblank(hblank), .vblank(vblank),
      .de(de), .frame_start(frame_start)
   );

   always #5 clk_pix = ~clk_pix;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [OW-1:0] observed();
      return {r, g, b, hs, vs, hblank, vblank, de, frame_start};
   endfunction

   task automatic model_reset();
      m_t       = 0;
      m_edges   = 0;
      m_last_fs = 0;
      m_phase   = 0;
      m_mode    = 0;
      m_color   = '0;
      m_lfsr    = 23'h7FFFFF;
      m_hb      = 1'b1;
      m_vb      = 1'b1;
      m_hs      = 1'b0;
      m_vs      = 1'b0;
   endtask

   // Called at a falling edge: predicts the next edge's outputs, then compares after it.
   task automatic step_cycle();
      int hc, vc, x, idx, wave, base, n, pix, k, cur_mode;
      bit h_last, wrap, ede;
      logic [DW-1:0] er, eg, eb;
      logic [OW-1:0] exp_v;
      hc     = m_t % HT;
      vc     = (m_t / HT) % VT;
      h_last = (hc == HT - 1);
      wrap   = h_last && (vc == VT - 1);
      if (hc == HBS) m_hb = 1'b1; else if (hc == HBE) m_hb = 1'b0;
      if (hc == HSS) m_hs = 1'b1; else if (hc == HSE) m_hs = 1'b0;
      if (h_last) begin
         if (vc == VBS) m_vb = 1'b1; else if (vc == VBE) m_vb = 1'b0;
         if (vc == VSS) m_vs = 1'b1; else if (vc == VSE) m_vs = 1'b0;
      end
      ede      = !m_hb && !m_vb;
      x        = (hc - HBE + HT) % HT;
      cur_mode = m_mode;
      case (cur_mode)
         0: begin
            idx  = (m_phase + 4 * vc) % 256;
            wave = (idx < 128) ? idx : 255 - idx;
            base = 2**(DW-1) + wave / 2**(8-DW);
            n    = int'(m_lfsr) % 2**NB;
            pix  = (base >= n) ? base - n : 0;
            er = DW'(pix); eg = DW'(pix); eb = DW'(pix);
         end
         1: {er, eg, eb} = m_color;
         2: begin
            k  = (x / 2**BS) % 8;
            er = ((k & 4) != 0) ? '0 : DW'(MAXV);
            eg = ((k & 2) != 0) ? '0 : DW'(MAXV);
            eb = ((k & 1) != 0) ? '0 : DW'(MAXV);
         end
         default: begin
            pix = (x / 2**GS) % 2**DW;
            er = DW'(pix); eg = DW'(pix); eb = DW'(pix);
         end
      endcase
      if (!ede) begin
         er = '0; eg = '0; eb = '0;
      end
      exp_v = {er, eg, eb, m_hs, m_vs, m_hb, m_vb, ede, wrap};
      if (wrap) begin
         m_mode  = int'(mode);
         m_color = color;
         if (!freeze) m_phase = (m_phase + STEP) % 256;
         m_fs_cnt++;
      end
      m_lfsr = {m_lfsr[21:0], m_lfsr[22] ^ m_lfsr[17]};
      m_t++;
      m_edges++;
      @(posedge clk_pix);
      #1;
      check("pixel_timing", 64'(observed()), 64'(exp_v));
      if (frame_start === 1'b1) begin
         dut_fs_cnt++;
         check("fs_period", 64'(m_edges - m_last_fs), 64'(FRAME));
         m_last_fs = m_edges;
      end
      if (cur_mode == 0 && ede)
         check("wave_range", 64'((int'(r) >= LO) && (int'(r) <= MAXV)), 64'(1));
      @(negedge clk_pix);
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) step_cycle();
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      #2 reset_n = 1'b0;
      #1 check("reset_async", 64'(observed()), 64'(RST_VEC));
      @(negedge clk_pix);
      @(negedge clk_pix);
      check("reset_hold", 64'(observed()), 64'(RST_VEC));
      reset_n = 1'b1;

      // Two default frames, then mid-frame mode changes that must wait for frame_start.
      run_cycles(2 * FRAME);
      run_cycles(FRAME / 2 + 7);
      mode  = 2'd1;
      color = {6'h3F, 6'h00, 6'h15};
      run_cycles(FRAME + FRAME / 2);
      mode = 2'd2;
      run_cycles(2 * FRAME);
      mode = 2'd3;
      run_cycles(FRAME);

      // Long unfrozen noise-wave run wraps the phase, then a frozen stretch.
      mode = 2'd0;
      run_cycles(44 * FRAME);
      freeze = 1'b1;
      run_cycles(2 * FRAME);

      for (int i = 0; i < 8; i++) begin
         run_cycles($urandom_range(50, 1500));
         mode   = 2'($urandom);
         color  = 18'($urandom);
         freeze = 1'($urandom);
      end

      // Park mid-line in the active area, then pulse reset without a clock edge.
      for (int i = 0; i < FRAME; i++) begin
         if ((m_t % HT) == 20 && ((m_t / HT) % VT) == 5) break;
         step_cycle();
      end
      #2 reset_n = 1'b0;
      #1 check("reset_midline", 64'(observed()), 64'(RST_VEC));
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_pix);
         @(negedge clk_pix);
         check("reset_held", 64'(observed()), 64'(RST_VEC));
      end
      reset_n = 1'b0;
      model_reset();
      reset_n = 1'b1;
      mode    = 2'd2;
      freeze  = 1'b0;
      run_cycles(2 * FRAME);

      check("fs_count", 64'(dut_fs_cnt), 64'(m_fs_cnt));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
